// File: rtl/call_dispatch.sv
// Hall-call dispatcher: latches hall-button presses, picks one request at a
// time round-robin, hands its code to the lift FSM for one cycle, then holds
// off for GAP cycles so the lift can complete the move. It also tracks where
// the lift will end up after each issued request.
module call_dispatch #(
  parameter int GAP = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] btn,
  output logic [2:0] code,
  output logic       code_vld,
  output logic [5:0] pending,
  output logic [1:0] cur_floor,
  output logic       busy
);

  localparam logic [3:0] GAP_CNT = 4'(GAP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] last_grant;
  logic [2:0] code_q;
  logic [2:0] grant_idx;
  logic       grant_found;
  logic [3:0] cand;
  logic       take;
  logic [5:0] grant_mask;

  // Request code driven to the lift FSM for each hall-button bit.
  function automatic logic [2:0] code_of(input logic [2:0] idx);
    case (idx)
      3'd0:    code_of = 3'b001;  // 1U
      3'd1:    code_of = 3'b010;  // 2U
      3'd2:    code_of = 3'b011;  // 3U
      3'd3:    code_of = 3'b110;  // 2D
      3'd4:    code_of = 3'b111;  // 3D
      3'd5:    code_of = 3'b100;  // 4D
      default: code_of = 3'b000;
    endcase
  endfunction

  // Floor the lift reaches after serving a request: up calls end one floor
  // above their source, down calls one floor below.
  function automatic logic [1:0] floor_of(input logic [2:0] idx);
    case (idx)
      3'd0:    floor_of = 2'd1;
      3'd1:    floor_of = 2'd2;
      3'd2:    floor_of = 2'd3;
      3'd3:    floor_of = 2'd0;
      3'd4:    floor_of = 2'd1;
      3'd5:    floor_of = 2'd2;
      default: floor_of = 2'd0;
    endcase
  endfunction

  // Round-robin search: first pending bit after the last grant, wrapping 5->0.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    cand        = 4'd0;
    for (int i = 1; i <= 6; i++) begin
      cand = {1'b0, last_grant} + 4'(i);
      if (cand >= 4'd6) cand = cand - 4'd6;
      if (!grant_found && pending[cand[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[2:0];
      end
    end
  end

  // Next-state and hold-off counter logic for the IDLE/ISSUE/WAIT sequence.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          state_nxt = ISSUE;
          take      = 1'b1;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
        cnt_nxt   = GAP_CNT;
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_mask = take ? (6'b000001 << grant_idx) : 6'b000000;

  // State register, request latch and grant bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      pending    <= 6'b000000;
      last_grant <= 3'd5;
      code_q     <= 3'b000;
      cur_floor  <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      // A press arriving on the grant edge survives as a fresh request.
      pending <= (pending & ~grant_mask) | btn;
      if (take) begin
        last_grant <= grant_idx;
        code_q     <= code_of(grant_idx);
        cur_floor  <= floor_of(grant_idx);
      end
    end
  end

  // Outputs are qualified by state so code is 000 outside ISSUE.
  assign code_vld = (state == ISSUE);
  assign code     = code_vld ? code_q : 3'b000;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_call_dispatch.sv
// Bench for call_dispatch: two instances (GAP=3 and GAP=1) share stimulus and
// are compared every cycle against a timeline model of the dispatch rules,
// alongside a vector table and directed corner-case sequences.
module tb_call_dispatch;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] btn;

  logic [2:0] code3, code1;
  logic       vld3, vld1;
  logic [5:0] pend3, pend1;
  logic [1:0] floor3, floor1;
  logic       busy3, busy1;

  always #5 clk = ~clk;

  call_dispatch #(.GAP(3)) dut3 (
    .clk(clk), .rst(rst), .btn(btn), .code(code3), .code_vld(vld3),
    .pending(pend3), .cur_floor(floor3), .busy(busy3)
  );

  call_dispatch #(.GAP(1)) dut1 (
    .clk(clk), .rst(rst), .btn(btn), .code(code1), .code_vld(vld1),
    .pending(pend1), .cur_floor(floor1), .busy(busy1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Timeline model: a request is granted at edge t, so the next grant may
  // happen no earlier than edge t+GAP+2; code_vld is high right after edge t,
  // busy covers edges t..t+GAP.
  int         gaps[2]     = '{3, 1};
  int         code_tab[6] = '{1, 2, 3, 6, 7, 4};
  int         cyc;
  logic [5:0] m_pend[2];
  int         m_last[2];
  int         m_floor[2];
  int         m_tiss[2];
  int         m_code[2];

  task automatic model_reset();
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      m_pend[k]  = 6'b0;
      m_last[k]  = 5;
      m_floor[k] = 0;
      m_tiss[k]  = -100;
      m_code[k]  = 0;
    end
  endtask

  task automatic model_edge(input logic [5:0] b);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      int g;
      g = -1;
      if (cyc >= m_tiss[k] + gaps[k] + 2 && m_pend[k] != 6'b0) begin
        for (int i = 1; i <= 6; i++) begin
          int idx;
          idx = (m_last[k] + i) % 6;
          if (g < 0 && m_pend[k][idx]) g = idx;
        end
        m_pend[k][g] = 1'b0;
        m_last[k]    = g;
        m_tiss[k]    = cyc;
        m_code[k]    = code_tab[g];
        m_floor[k]   = (g < 3) ? g + 1 : g - 3;
      end
      m_pend[k] = m_pend[k] | b;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [2:0] ac;
      logic       av, ab, ev, eb;
      logic [5:0] ap;
      logic [1:0] af;
      ac = (k == 0) ? code3  : code1;
      av = (k == 0) ? vld3   : vld1;
      ap = (k == 0) ? pend3  : pend1;
      af = (k == 0) ? floor3 : floor1;
      ab = (k == 0) ? busy3  : busy1;
      ev = (cyc == m_tiss[k]);
      eb = (cyc <= m_tiss[k] + gaps[k]);
      check($sformatf("gap%0d_code_c%0d", gaps[k], cyc), ac, ev ? m_code[k] : 0);
      check($sformatf("gap%0d_vld_c%0d", gaps[k], cyc), av, ev);
      check($sformatf("gap%0d_pending_c%0d", gaps[k], cyc), ap, m_pend[k]);
      check($sformatf("gap%0d_floor_c%0d", gaps[k], cyc), af, m_floor[k]);
      check($sformatf("gap%0d_busy_c%0d", gaps[k], cyc), ab, eb);
    end
  endtask

  // Drive btn for one edge (called at a falling edge), sample 1 time unit
  // after the rising edge, return at the next falling edge.
  task automatic tick(input logic [5:0] b);
    btn = b;
    @(posedge clk);
    #1;
    model_edge(b);
    compare_all();
    @(negedge clk);
  endtask

  // Asynchronous reset applied mid-cycle with every button held down.
  task automatic do_reset();
    rst = 1'b1;
    btn = 6'h3f;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    btn = 6'b0;
  endtask

  typedef struct {
    logic [5:0] b;
    logic [2:0] code;
    logic       vld;
    logic [5:0] pend;
    logic [1:0] floor;
    logic       busy;
  } vec_t;

  vec_t vt[7];
  int   pc[$];
  int   pcode[$];

  initial begin
    int exp27[6];
    exp27 = '{1, 2, 3, 6, 7, 4};
    rst = 1'b1;
    btn = 6'b0;
    model_reset();
    @(negedge clk);

    // Single 1U press on the GAP=3 instance, expected values per cycle.
    vt[0] = '{6'b000001, 3'b000, 1'b0, 6'b000001, 2'd0, 1'b0};
    vt[1] = '{6'b000000, 3'b001, 1'b1, 6'b000000, 2'd1, 1'b1};
    vt[2] = '{6'b000000, 3'b000, 1'b0, 6'b000000, 2'd1, 1'b1};
    vt[3] = '{6'b000000, 3'b000, 1'b0, 6'b000000, 2'd1, 1'b1};
    vt[4] = '{6'b000000, 3'b000, 1'b0, 6'b000000, 2'd1, 1'b1};
    vt[5] = '{6'b000000, 3'b000, 1'b0, 6'b000000, 2'd1, 1'b0};
    vt[6] = '{6'b000000, 3'b000, 1'b0, 6'b000000, 2'd1, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick(vt[i].b);
      check($sformatf("vec%0d_code", i), code3, vt[i].code);
      check($sformatf("vec%0d_vld", i), vld3, vt[i].vld);
      check($sformatf("vec%0d_pending", i), pend3, vt[i].pend);
      check($sformatf("vec%0d_floor", i), floor3, vt[i].floor);
      check($sformatf("vec%0d_busy", i), busy3, vt[i].busy);
    end

    // All six buttons at once: issued in bit order, 5 cycles apart.
    do_reset();
    tick(6'h3f);
    pc.delete();
    pcode.delete();
    for (int i = 0; i < 40; i++) begin
      tick(6'b0);
      if (vld3) begin
        pc.push_back(i);
        pcode.push_back(int'(code3));
      end
    end
    check("all6_count", pc.size(), 6);
    for (int j = 0; j < 6 && j < pc.size(); j++) begin
      check($sformatf("all6_code%0d", j), pcode[j], exp27[j]);
      if (j > 0) check($sformatf("all6_space%0d", j), pc[j] - pc[j-1], 5);
    end
    check("all6_final_floor", floor3, 2);
    check("all6_final_pending", pend3, 0);

    // Press on the grant edge of the same bit: kept and reissued GAP+2 later.
    do_reset();
    tick(6'b000100);
    tick(6'b000100);
    check("repress_code", code3, 3'b011);
    check("repress_vld", vld3, 1'b1);
    check("repress_pending", pend3, 6'b000100);
    for (int i = 0; i < 4; i++) begin
      tick(6'b0);
      check($sformatf("repress_gap_vld%0d", i), vld3, 1'b0);
    end
    tick(6'b0);
    check("repress_reissue_vld", vld3, 1'b1);
    check("repress_reissue_code", code3, 3'b011);
    check("repress_reissue_pending", pend3, 6'b0);

    // Round-robin wrap: after granting bit4, bit5 wins over bit0.
    do_reset();
    tick(6'b010000);
    tick(6'b0);
    check("wrap_first_code", code3, 3'b111);
    tick(6'b100001);
    pc.delete();
    pcode.delete();
    for (int i = 0; i < 15; i++) begin
      tick(6'b0);
      if (vld3) begin
        pc.push_back(i);
        pcode.push_back(int'(code3));
      end
    end
    check("wrap_count", pc.size(), 2);
    if (pc.size() >= 2) begin
      check("wrap_order0", pcode[0], 3'b100);
      check("wrap_order1", pcode[1], 3'b001);
      check("wrap_space", pc[1] - pc[0], 5);
    end

    // Reset during WAIT discards latched requests and suppresses any pulse.
    do_reset();
    tick(6'b001100);
    tick(6'b0);
    check("abort_issue_code", code3, 3'b011);
    tick(6'b000100);
    check("abort_wait_pending", pend3, 6'b001100);
    check("abort_wait_busy", busy3, 1'b1);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick(6'b0);
      check($sformatf("abort_quiet_vld3_%0d", i), vld3, 1'b0);
      check($sformatf("abort_quiet_vld1_%0d", i), vld1, 1'b0);
    end

    // GAP=1 with two requests: pulses 3 cycles apart, code idle otherwise.
    do_reset();
    tick(6'b000011);
    pc.delete();
    pcode.delete();
    for (int i = 0; i < 10; i++) begin
      tick(6'b0);
      if (vld1) begin
        pc.push_back(i);
        pcode.push_back(int'(code1));
      end else begin
        check($sformatf("gap1_idle_code%0d", i), code1, 3'b000);
      end
    end
    check("gap1_count", pc.size(), 2);
    if (pc.size() >= 2) begin
      check("gap1_code0", pcode[0], 3'b001);
      check("gap1_code1", pcode[1], 3'b010);
      check("gap1_space", pc[1] - pc[0], 3);
    end

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [5:0] b;
      b = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
      if ($urandom_range(0, 149) == 0) do_reset();
      tick(b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/call_dispatch.md
CALL_DISPATCH -- requirements
Module: call_dispatch

Interface
REQ-001 Parameter GAP, default 3, range 1..15: idle cycles inserted after each issued code so the lift FSM can finish the move.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 btn  input  6  hall-button pulses: bit0=1U, bit1=2U, bit2=3U, bit3=2D, bit4=3D, bit5=4D; any combination per cycle is legal.
REQ-005 code  output  3  request code to the lift FSM: 1U=001, 2U=010, 3U=011, 2D=110, 3D=111, 4D=100; 000 = no request.
REQ-006 code_vld  output  1  high for exactly the one cycle in which code carries a request.
REQ-007 pending  output  6  latched, not-yet-issued requests (hall lamps), same bit order as btn.
REQ-008 cur_floor  output  2  tracked lift position, 0..3 = floors 1..4.
REQ-009 busy  output  1  high while the FSM is in ISSUE or WAIT.

Function
REQ-010 Pending latch: btn[i]=1 at an edge sets pending[i]; repeat presses of a set bit have no further effect.
REQ-011 Press and grant of the same bit at the same edge: the bit stays set (the new press is kept as a new request).
REQ-012 FSM states IDLE, ISSUE, WAIT; reset state IDLE.
REQ-013 IDLE: if pending != 0 at an edge -> ISSUE, grant one bit, clear it, load code register; else remain IDLE.
REQ-014 ISSUE lasts exactly one cycle: code = granted code, code_vld = 1; next edge -> WAIT with the 4-bit counter loaded with GAP.
REQ-015 WAIT: counter decrements each edge; when it reaches 0 -> IDLE; code = 000, code_vld = 0 throughout.
REQ-016 Minimum spacing between code_vld pulses with back-to-back pending requests = GAP+2 cycles.
REQ-017 Arbitration: round-robin over the 6 bits; search starts at (last_grant+1) mod 6 and wraps 5->0; last_grant resets to 5.
REQ-018 Presses arriving during ISSUE/WAIT are latched and considered only at the next IDLE evaluation.
REQ-019 Floor tracking on grant: up codes set cur_floor = source+1 (1U->1, 2U->2, 3U->3); down codes set cur_floor = source-1 (2D->0, 3D->1, 4D->2).
REQ-020 cur_floor saturates within 0..3 by construction; no other arithmetic wraps.
REQ-021 Outside ISSUE: code = 000, code_vld = 0.
REQ-022 busy = 1 in ISSUE and WAIT, 0 in IDLE.

Reset
REQ-023 rst asserted: immediately state = IDLE, pending = 0, code = 000, code_vld = 0, busy = 0, cur_floor = 0, counter = 0, last_grant = 5.
REQ-024 rst asserted mid-ISSUE or mid-WAIT aborts the operation; all latched requests are discarded; no code_vld pulse follows.
REQ-025 btn is ignored while rst is high; first sampling at the first edge after release.

Verification
REQ-026 Reset, btn=000001 for one cycle -> pending=000001 next edge; next edge code=001, code_vld=1 for one cycle, pending=0, cur_floor=1; busy for GAP+1 cycles.
REQ-027 btn=111111 in one cycle, GAP=3 -> codes issued in order 001,010,011,110,111,100 spaced 5 cycles apart; final cur_floor=2; pending clears bit by bit.
REQ-028 Grant of bit 2 (3U) while btn[2] pressed at the same edge -> code=011 issued, pending[2] remains 1, reissued after GAP+2 cycles.
REQ-029 Round-robin wrap: last_grant=4, pending=100001 -> bit5 (100) granted first, then bit0 (001).
REQ-030 rst pulsed during WAIT with pending=001100 -> all outputs at reset values, no code_vld for any cycle until a new press.
REQ-031 GAP=1, two pending bits -> code_vld pulses exactly 3 cycles apart; code=000 in every non-ISSUE cycle.
